// File: rtl/payload_packer.sv
// payload_packer: packs each contiguous in_valid burst (one frame) MSB-first
// into DW-bit words, tags the final word of the frame with last/nbits, and
// queues words in a DEPTH-entry show-ahead FIFO with a valid/ready output.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-low reset
//   in_valid, in_bit   gated serial stream from the upstream stage
//   out_valid/ready    FIFO head handshake
//   out_data/last/nbits  head word (left-aligned), last-of-frame flag, bit count
//   frame_done         one-cycle pulse after a frame's last word is queued
//   frame_bits         saturating bit count of the most recent frame
//   overflow           sticky: a word was dropped on a full FIFO
module payload_packer #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_bit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW-1:0]             out_data,
    output logic                      out_last,
    output logic [$clog2(DW+1)-1:0]   out_nbits,
    output logic                      frame_done,
    output logic [CNTW-1:0]           frame_bits,
    output logic                      overflow
);

    localparam int unsigned NBW = $clog2(DW + 1);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned EW  = DW + 1 + NBW;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t            state, state_d;
    logic [DW-1:0]     shreg, shreg_d;
    logic [NBW-1:0]    cnt, cnt_d;
    logic              stage_valid, stage_valid_d;
    logic [DW-1:0]     stage_data, stage_data_d;
    logic [CNTW-1:0]   fcnt, fcnt_d;
    logic              frame_done_d;
    logic [CNTW-1:0]   frame_bits_d;
    logic              push;
    logic [EW-1:0]     push_word;
    logic [DW-1:0]     shifted;
    logic [NBW-1:0]    cnt_inc;

    logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [EW-1:0]     mem [DEPTH];
    logic              full, pop, do_write;
    logic [EW-1:0]     head_d;

    // Frame FSM, bit accumulation and word staging; at most one push per edge.
    always_comb begin
        state_d       = state;
        shreg_d       = shreg;
        cnt_d         = cnt;
        stage_valid_d = stage_valid;
        stage_data_d  = stage_data;
        fcnt_d        = fcnt;
        frame_done_d  = 1'b0;
        frame_bits_d  = frame_bits;
        push          = 1'b0;
        push_word     = '0;
        shifted       = {shreg[DW-2:0], in_bit};
        cnt_inc       = cnt + NBW'(1);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = COLLECT;
                    shreg_d = DW'(in_bit);
                    cnt_d   = NBW'(1);
                    fcnt_d  = CNTW'(1);
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    // A staged word is only known to be non-final once another bit arrives.
                    if (stage_valid) begin
                        push          = 1'b1;
                        push_word     = {stage_data, 1'b0, NBW'(DW)};
                        stage_valid_d = 1'b0;
                    end
                    if (fcnt != '1) begin
                        fcnt_d = fcnt + CNTW'(1);
                    end
                    if (cnt_inc == NBW'(DW)) begin
                        stage_valid_d = 1'b1;
                        stage_data_d  = shifted;
                        shreg_d       = '0;
                        cnt_d         = '0;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    push          = 1'b1;
                    state_d       = IDLE;
                    frame_done_d  = 1'b1;
                    frame_bits_d  = fcnt;
                    shreg_d       = '0;
                    cnt_d         = '0;
                    stage_valid_d = 1'b0;
                    // Either a full word is staged or the shift register holds 1..DW-1 bits.
                    if (stage_valid) begin
                        push_word = {stage_data, 1'b1, NBW'(DW)};
                    end else begin
                        push_word = {DW'(shreg << (NBW'(DW) - cnt)), 1'b1, cnt};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer update and next head word for the registered show-ahead outputs.
    always_comb begin
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop      = out_valid & out_ready;
        do_write = push & (~full | pop);
        wr_ptr_d = wr_ptr + PW'(do_write);
        rd_ptr_d = rd_ptr + PW'(pop);
        if (wr_ptr_d == rd_ptr_d) begin
            head_d = '0;
        end else if (do_write && (rd_ptr_d[AW-1:0] == wr_ptr[AW-1:0])) begin
            // The word being written this edge becomes the head.
            head_d = push_word;
        end else begin
            head_d = mem[rd_ptr_d[AW-1:0]];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath, FIFO pointers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg       <= '0;
            cnt         <= '0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
            fcnt        <= '0;
            frame_done  <= 1'b0;
            frame_bits  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_nbits   <= '0;
            overflow    <= 1'b0;
        end else begin
            shreg       <= shreg_d;
            cnt         <= cnt_d;
            stage_valid <= stage_valid_d;
            stage_data  <= stage_data_d;
            fcnt        <= fcnt_d;
            frame_done  <= frame_done_d;
            frame_bits  <= frame_bits_d;
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            out_valid   <= (wr_ptr_d != rd_ptr_d);
            {out_data, out_last, out_nbits} <= head_d;
            overflow    <= overflow | (push & full & ~pop);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

endmodule

// File: tb/tb_payload_packer.sv
// Bench for payload_packer: directed frames plus random traffic, checked
// against a bit-list reference model and a word scoreboard.
module tb_payload_packer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;
    localparam int NBW   = $clog2(DW + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_bit = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [NBW-1:0]    out_nbits;
    logic              frame_done;
    logic [CNTW-1:0]   frame_bits;
    logic              overflow;

    always #5 clk = ~clk;

    payload_packer #(.DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_nbits  (out_nbits),
        .frame_done (frame_done),
        .frame_bits (frame_bits),
        .overflow   (overflow)
    );

    typedef struct packed {
        logic [DW-1:0]  data;
        logic           last;
        logic [NBW-1:0] nbits;
    } word_t;

    word_t sb[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: bits of the current frame, FIFO occupancy, frame bookkeeping.
    bit    m_in_frame = 1'b0;
    bit    m_held[$];
    int    m_fbits = 0;
    int    m_cnt = 0;
    bit    m_ovf = 1'b0;
    bit    m_done = 1'b0;
    int    m_frame_bits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Left-align the held bits into one word and empty the bit list.
    function automatic word_t pack_word(input bit last_w);
        word_t w;
        w = '0;
        for (int i = 0; i < m_held.size(); i++) begin
            w.data[DW-1-i] = m_held[i];
        end
        w.last  = last_w;
        w.nbits = NBW'(m_held.size());
        m_held.delete();
        return w;
    endfunction

    task automatic model_reset();
        m_in_frame   = 1'b0;
        m_held.delete();
        m_fbits      = 0;
        m_cnt        = 0;
        m_ovf        = 1'b0;
        m_done       = 1'b0;
        m_frame_bits = 0;
        sb.delete();
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_step();
        word_t w;
        bit    have;
        bit    pop;
        have   = 1'b0;
        w      = '0;
        pop    = (m_cnt > 0) && out_ready;
        m_done = 1'b0;
        if (in_valid) begin
            if (!m_in_frame) begin
                m_in_frame = 1'b1;
                m_fbits    = 0;
            end
            if (m_held.size() == DW) begin
                w    = pack_word(1'b0);
                have = 1'b1;
            end
            m_held.push_back(in_bit);
            if (m_fbits < (1 << CNTW) - 1) m_fbits++;
        end else if (m_in_frame) begin
            w            = pack_word(1'b1);
            have         = 1'b1;
            m_in_frame   = 1'b0;
            m_done       = 1'b1;
            m_frame_bits = m_fbits;
        end
        if (pop) m_cnt--;
        if (have) begin
            if (m_cnt < DEPTH) begin
                sb.push_back(w);
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // Per-cycle status checks, then model update for the next edge.
    always @(negedge clk) begin
        if (!rst) model_reset();
        check("out_valid", 32'(out_valid), 32'(m_cnt > 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_done", 32'(frame_done), 32'(m_done));
        check("frame_bits", 32'(frame_bits), 32'(m_frame_bits));
        if (!out_valid) check("empty_outputs_zero", 32'({out_data, out_last, out_nbits}), 32'd0);
        if (rst) model_step();
    end

    // Scoreboard monitor: compare the presented head; retire it on a handshake.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head_word: got %0h with no word expected at %0t", out_data, $time);
            end else begin
                check("out_data", 32'(out_data), 32'(sb[0].data));
                check("out_last", 32'(out_last), 32'(sb[0].last));
                check("out_nbits", 32'(out_nbits), 32'(sb[0].nbits));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic b, input logic r);
        in_valid  = v;
        in_bit    = b;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, r);
    endtask

    // Send n bits of v, MSB first, followed by one gap cycle.
    task automatic send(input logic [63:0] v, input int n, input logic r);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, v[i], r);
        cyc(1'b0, 1'b0, r);
    endtask

    initial begin
        logic [7:0] part;
        part = 8'b10110;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2, 1'b1);

        // Single full word, then 11-bit frame spanning two words.
        send(64'hB3, 8, 1'b1);
        idle(3, 1'b1);
        send(64'h52D, 11, 1'b1);
        idle(3, 1'b1);

        // Five frames into a stalled FIFO: fifth word dropped, then drain.
        for (int k = 1; k <= 5; k++) send(64'(k * 8'h11), 8, 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);

        // Short frames separated by a single idle cycle.
        send(64'h7, 3, 1'b1);
        send(64'h1, 2, 1'b1);
        idle(3, 1'b1);

        // Reset in the middle of a frame, then a clean frame.
        for (int i = 4; i >= 0; i--) cyc(1'b1, part[i], 1'b1);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        idle(1, 1'b1);
        send(64'h3C, 8, 1'b1);
        idle(3, 1'b1);

        // Full FIFO with a pop on the same edge as a frame-end push.
        for (int k = 0; k < DEPTH; k++) send(64'($urandom_range(0, 255)), 8, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'($urandom), 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        idle(3, 1'b0);
        idle(8, 1'b1);

        // Long frame to saturate frame_bits.
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'($urandom), 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 9) < 8), 1'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(20, 1'b1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
